vector_ram_responder: RTL and testbench

// - Memory-side responder for the 256-bit vector load/store RAM port driven by the datapath's

---
 rtl/vector_ram_responder_if.sv | 23 ++
 rtl/vector_ram_responder.sv | 98 +++++++++
 tb/tb_vector_ram_responder.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/vector_ram_responder_if.sv
// rtl/vector_ram_responder_if.sv - vector load/store RAM port bundle between the LSU and the responder
interface vector_ram_responder_if;
    logic [13:0]  address;
    logic [31:0]  byteena;
    logic [255:0] data;
    logic         rden;
    logic         wren;
    logic [255:0] q;
    logic         q_valid;
    logic         addr_err;
    logic [31:0]  rd_count;
    logic [31:0]  wr_count;

    modport master (
        output address, byteena, data, rden, wren,
        input  q, q_valid, addr_err, rd_count, wr_count
    );

    modport slave (
        input  address, byteena, data, rden, wren,
        output q, q_valid, addr_err, rd_count, wr_count
    );
endinterface

// File: rtl/vector_ram_responder.sv
// rtl/vector_ram_responder.sv - 256-bit line RAM responder with byte-masked writes and fixed-latency reads
module vector_ram_responder #(
    parameter int DEPTH    = 16384,
    parameter int READ_LAT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    vector_ram_responder_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [255:0] mem_q [DEPTH];
    logic         in_range;
    logic [AW-1:0] idx;
    logic [255:0] rd_line;
    logic         fin_valid;
    logic [255:0] fin_data;

    logic [255:0] q_q;
    logic         q_valid_q;
    logic         err_q, err_d;
    logic [31:0]  rd_count_q, rd_count_d;
    logic [31:0]  wr_count_q, wr_count_d;

    assign in_range = ({18'd0, bus.address} < 32'(DEPTH));
    assign idx      = bus.address[AW-1:0];
    // Combinational fetch ahead of the write below gives read-before-write on a shared edge.
    assign rd_line  = in_range ? mem_q[idx] : '0;

    always_ff @(posedge clk) begin
        if (!reset && bus.wren && in_range) begin
            for (int i = 0; i < 32; i++) begin
                if (bus.byteena[i]) begin
                    mem_q[idx][8*i +: 8] <= bus.data[8*i +: 8];
                end
            end
        end
    end

    // The output register is the last stage, so READ_LAT-1 stages sit in front of it.
    generate
        if (READ_LAT == 1) begin : g_no_shift
            assign fin_valid = bus.rden;
            assign fin_data  = rd_line;
        end else begin : g_shift
            logic [READ_LAT-2:0] sh_valid_q;
            logic [255:0]        sh_data_q [READ_LAT-1];

            always_ff @(posedge clk) begin
                if (reset) begin
                    sh_valid_q <= '0;
                end else begin
                    sh_valid_q[0] <= bus.rden;
                    for (int k = 1; k < READ_LAT - 1; k++) begin
                        sh_valid_q[k] <= sh_valid_q[k-1];
                    end
                end
                sh_data_q[0] <= rd_line;
                for (int k = 1; k < READ_LAT - 1; k++) begin
                    sh_data_q[k] <= sh_data_q[k-1];
                end
            end

            assign fin_valid = sh_valid_q[READ_LAT-2];
            assign fin_data  = sh_data_q[READ_LAT-2];
        end
    endgenerate

    always_comb begin
        rd_count_d = rd_count_q + {31'd0, bus.rden};
        wr_count_d = wr_count_q + {31'd0, bus.wren};
        err_d      = err_q | ((bus.rden | bus.wren) & ~in_range);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q        <= '0;
            q_valid_q  <= 1'b0;
            err_q      <= 1'b0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            q_valid_q  <= fin_valid;
            if (fin_valid) begin
                q_q <= fin_data;
            end
            err_q      <= err_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign bus.q        = q_q;
    assign bus.q_valid  = q_valid_q;
    assign bus.addr_err = err_q;
    assign bus.rd_count = rd_count_q;
    assign bus.wr_count = wr_count_q;
endmodule

// File: tb/tb_vector_ram_responder.sv
// tb/tb_vector_ram_responder.sv - randomized and directed bench against a queue-based reference model
module tb_vector_ram_responder;
    localparam int DEPTH = 1024;
    localparam int RL    = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vector_ram_responder_if bus ();

    vector_ram_responder #(.DEPTH(DEPTH), .READ_LAT(RL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Reference model: reads become timestamped entries in a queue, released on their due edge.
    typedef struct {
        int           due;
        logic [255:0] d;
    } rd_t;

    logic [255:0] m_mem [DEPTH];
    rd_t          pend [$];
    int           edge_n = 0;
    logic [255:0] m_q;
    logic         m_valid, m_err, m_ok;
    logic [31:0]  m_rd, m_wr;
    bit           live = 0;

    always @(posedge clk) begin
        edge_n++;
        if (reset) begin
            pend.delete();
            m_q = '0; m_valid = 0; m_err = 0; m_rd = 0; m_wr = 0;
            live = 1;
        end else begin
            m_ok = (int'(bus.address) < DEPTH);
            if (bus.rden) begin
                pend.push_back('{due: edge_n + RL - 1, d: (m_ok ? m_mem[bus.address] : '0)});
                m_rd++;
            end
            if (bus.wren) begin
                m_wr++;
                if (m_ok)
                    for (int i = 0; i < 32; i++)
                        if (bus.byteena[i]) m_mem[bus.address][8*i +: 8] = bus.data[8*i +: 8];
            end
            if ((bus.rden || bus.wren) && !m_ok) m_err = 1;
            m_valid = 0;
            if (pend.size() > 0 && pend[0].due == edge_n) begin
                m_q     = pend[0].d;
                m_valid = 1;
                void'(pend.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            check("q", bus.q, m_q);
            check("q_valid", 256'(bus.q_valid), 256'(m_valid));
            check("addr_err", 256'(bus.addr_err), 256'(m_err));
            check("rd_count", 256'(bus.rd_count), 256'(m_rd));
            check("wr_count", 256'(bus.wr_count), 256'(m_wr));
        end
    end

    task automatic idle();
        bus.rden = 1'b0;
        bus.wren = 1'b0;
    endtask

    task automatic do_write(input logic [13:0] a, input logic [31:0] be, input logic [255:0] d);
        bus.address = a; bus.byteena = be; bus.data = d;
        bus.wren = 1'b1; bus.rden = 1'b0;
        @(negedge clk);
        idle();
    endtask

    task automatic do_read(input logic [13:0] a, input logic wr, input logic [255:0] wd,
                           output logic [255:0] d, output int lat);
        bit got = 0;
        bus.address = a; bus.byteena = '1; bus.data = wd;
        bus.rden = 1'b1; bus.wren = wr;
        d = '0; lat = 0;
        for (int n = 0; n < 8 && !got; n++) begin
            @(negedge clk);
            idle();
            lat++;
            if (bus.q_valid) begin
                d = bus.q;
                got = 1;
            end
        end
        if (!got) begin
            failures++;
            $display("FAIL read_timeout actual=no_q_valid required=q_valid addr=%0d", a);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    logic [255:0] rd, pat;
    int           lat;
    logic [255:0] got_d [$];
    int           got_c [$];

    initial begin
        reset = 1'b1;
        bus.address = '0; bus.byteena = '0; bus.data = '0;
        idle();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_q", bus.q, '0);
        check("rst_q_valid", 256'(bus.q_valid), '0);
        check("rst_addr_err", 256'(bus.addr_err), '0);
        check("rst_rd_count", 256'(bus.rd_count), '0);
        check("rst_wr_count", 256'(bus.wr_count), '0);

        do_write(14'd5, '1, {32{8'hA5}});
        do_read(14'd5, 1'b0, '0, rd, lat);
        check("full_write", rd, {32{8'hA5}});
        check("read_latency", 256'(lat), 256'(RL));
        check("wr_count_1", 256'(bus.wr_count), 256'(1));
        check("rd_count_1", 256'(bus.rd_count), 256'(1));

        do_write(14'd5, 32'h0000_000F, {32{8'h11}});
        do_read(14'd5, 1'b0, '0, rd, lat);
        check("partial_write", rd, {{28{8'hA5}}, {4{8'h11}}});

        do_write(14'd9, '1, '0);
        do_read(14'd9, 1'b1, '1, rd, lat);
        check("rw_same_edge_old", rd, '0);
        do_read(14'd9, 1'b0, '0, rd, lat);
        check("rw_then_new", rd, '1);

        for (int k = 1; k <= 4; k++) do_write(14'(k), '1, {32{8'(k * 17)}});
        for (int n = 0; n < 12; n++) begin
            if (n < 4) begin
                bus.address = 14'(n + 1); bus.rden = 1'b1; bus.wren = 1'b0;
            end else begin
                idle();
            end
            @(negedge clk);
            if (bus.q_valid) begin
                got_d.push_back(bus.q);
                got_c.push_back(n + 1);
            end
        end
        check("b2b_count", 256'(got_d.size()), 256'(4));
        for (int j = 0; j < got_d.size() && j < 4; j++) begin
            check("b2b_data", got_d[j], {32{8'((j + 1) * 17)}});
            check("b2b_cycle", 256'(got_c[j]), 256'(j + RL));
        end

        pat = rand256();
        do_write(14'd976, '1, pat);
        do_read(14'd2000, 1'b0, '0, rd, lat);
        check("oor_read_zero", rd, '0);
        check("oor_err_set", 256'(bus.addr_err), 256'(1));
        do_write(14'd2000, '1, '1);
        repeat (3) @(negedge clk);
        check("oor_err_sticky", 256'(bus.addr_err), 256'(1));
        do_read(14'd976, 1'b0, '0, rd, lat);
        check("oor_write_dropped", rd, pat);

        bus.address = 14'd5; bus.rden = 1'b1; bus.wren = 1'b0;
        @(negedge clk);
        idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            check("flushed_no_valid", 256'(bus.q_valid), '0);
        end
        check("rst_rd_count_0", 256'(bus.rd_count), '0);
        check("rst_wr_count_0", 256'(bus.wr_count), '0);
        check("rst_err_clear", 256'(bus.addr_err), '0);
        do_read(14'd5, 1'b0, '0, rd, lat);
        check("mem_survives_reset", rd, {{28{8'hA5}}, {4{8'h11}}});

        for (int k = 0; k < 16; k++) do_write(14'(k), '1, rand256());
        for (int n = 0; n < 400; n++) begin
            bus.rden    = 1'($urandom_range(0, 1));
            bus.wren    = 1'($urandom_range(0, 1));
            bus.address = ($urandom_range(0, 9) == 0) ? 14'(1024 + $urandom_range(0, 15000))
                                                      : 14'($urandom_range(0, 15));
            bus.byteena = $urandom;
            bus.data    = rand256();
            @(negedge clk);
        end
        idle();
        repeat (6) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
